// File: rtl/buffered_data_register_pkg.sv
// Shared constants for the buffered data register: bus geometry, status bit
// positions, count field placement and control (write-1) bit positions.
package buffered_data_register_pkg;

  localparam int BUS_W  = 32;
  localparam int ADDR_W = 12;

  // Status register read layout
  localparam int STAT_TX_FULL     = 0;
  localparam int STAT_TX_EMPTY    = 1;
  localparam int STAT_RX_FULL     = 2;
  localparam int STAT_RX_EMPTY    = 3;
  localparam int STAT_TX_OVERFLOW = 4;
  localparam int STAT_RX_UNDERFL  = 5;
  localparam int STAT_TX_CNT_LSB  = 8;
  localparam int STAT_RX_CNT_LSB  = 16;
  localparam int STAT_CNT_W       = 5;

  // Status register write-1 actions
  localparam int CTRL_FLUSH_TX    = 0;
  localparam int CTRL_FLUSH_RX    = 1;
  localparam int CTRL_CLR_TX_OVF  = 4;
  localparam int CTRL_CLR_RX_UDF  = 5;

  // Bus access kind after strobe qualification
  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_READ  = 2'd2
  } acc_e;

  // Assemble the status word from its individual fields
  function automatic logic [BUS_W-1:0] pack_status(
    input logic                  tx_full,
    input logic                  tx_empty,
    input logic                  rx_full,
    input logic                  rx_empty,
    input logic                  tx_ovf,
    input logic                  rx_udf,
    input logic [STAT_CNT_W-1:0] tx_cnt,
    input logic [STAT_CNT_W-1:0] rx_cnt
  );
    logic [BUS_W-1:0] s;
    s = '0;
    s[STAT_TX_FULL]     = tx_full;
    s[STAT_TX_EMPTY]    = tx_empty;
    s[STAT_RX_FULL]     = rx_full;
    s[STAT_RX_EMPTY]    = rx_empty;
    s[STAT_TX_OVERFLOW] = tx_ovf;
    s[STAT_RX_UNDERFL]  = rx_udf;
    s[STAT_TX_CNT_LSB +: STAT_CNT_W] = tx_cnt;
    s[STAT_RX_CNT_LSB +: STAT_CNT_W] = rx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/buffered_data_register_sync_fifo.sv
// Synchronous FIFO with registered count; head reads as zero while empty.
// Flush takes priority over push and pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and count update; flush empties the FIFO regardless of push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write; the slot is dead after a flush so writing it is harmless
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = pushData;
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage carries no reset; empty masks stale contents on head
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/buffered_data_register.sv
// Bus-mapped data register fronted by a TX and an RX FIFO, with a
// status/control register and blocking or dropping full/empty behaviour.
module buffered_data_register
  import buffered_data_register_pkg::*;
#(
  parameter int                WIDTH          = 32,
  parameter int                DEPTH          = 4,
  parameter logic [ADDR_W-1:0] ADDRESS        = 12'h000,
  parameter logic [ADDR_W-1:0] STATUS_ADDRESS = 12'h004,
  parameter int                BLOCKING       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              peripheralBus_we,
  input  logic              peripheralBus_oe,
  output logic              peripheralBus_busy,
  input  logic [ADDR_W-1:0] peripheralBus_address,
  inout  wire  [BUS_W-1:0]  peripheralBus_data,
  output logic [WIDTH-1:0]  writeData,
  output logic              writeData_valid,
  input  logic              writeData_ready,
  input  logic [WIDTH-1:0]  readData,
  input  logic              readData_valid,
  output logic              readData_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam bit BLK   = (BLOCKING != 0);

  acc_e             acc;
  logic             sel_data, sel_stat;
  logic             data_wr, data_rd, stat_wr, stat_rd;
  logic [BUS_W-1:0] bus_in;
  logic [BUS_W-1:0] rd_word;
  logic [BUS_W-1:0] status_word;
  logic             bus_drive;
  logic             unused_bus;

  logic [WIDTH-1:0] tx_head, rx_head;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic             tx_flush, rx_flush;

  logic             tx_ovf_q, tx_ovf_d;
  logic             rx_udf_q, rx_udf_d;
  logic             tx_ovf_set, rx_udf_set;

  function automatic logic [BUS_W-1:0] zero_pad(input logic [WIDTH-1:0] v);
    logic [BUS_W-1:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign bus_in     = peripheralBus_data;
  assign unused_bus = ^bus_in;
  assign sel_data   = enable & (peripheralBus_address == ADDRESS);
  assign sel_stat   = enable & (peripheralBus_address == STATUS_ADDRESS);

  // Qualify strobes: both together means no access at all
  always_comb begin
    acc = ACC_NONE;
    if (peripheralBus_we && !peripheralBus_oe)      acc = ACC_WRITE;
    else if (peripheralBus_oe && !peripheralBus_we) acc = ACC_READ;
  end

  assign data_wr = sel_data & (acc == ACC_WRITE);
  assign data_rd = sel_data & (acc == ACC_READ);
  assign stat_wr = sel_stat & (acc == ACC_WRITE);
  assign stat_rd = sel_stat & (acc == ACC_READ);

  // Stall only on registered full/empty, and only in blocking mode
  assign peripheralBus_busy = BLK & ((data_wr & tx_full) | (data_rd & rx_empty));

  assign tx_push    = data_wr & ~tx_full;
  assign rx_pop     = data_rd & ~rx_empty;
  assign tx_pop     = writeData_ready & ~tx_empty;
  assign rx_push    = readData_valid & ~rx_full;
  assign tx_flush   = stat_wr & bus_in[CTRL_FLUSH_TX];
  assign rx_flush   = stat_wr & bus_in[CTRL_FLUSH_RX];
  assign tx_ovf_set = ~BLK & data_wr & tx_full;
  assign rx_udf_set = ~BLK & data_rd & rx_empty;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .pushData (bus_in[WIDTH-1:0]),
    .pop      (tx_pop),
    .flush    (tx_flush),
    .head     (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_push),
    .pushData (readData),
    .pop      (rx_pop),
    .flush    (rx_flush),
    .head     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  // Sticky error flags: a same-cycle clear wins over a set
  always_comb begin
    tx_ovf_d = tx_ovf_q | tx_ovf_set;
    rx_udf_d = rx_udf_q | rx_udf_set;
    if (stat_wr && bus_in[CTRL_CLR_TX_OVF]) tx_ovf_d = 1'b0;
    if (stat_wr && bus_in[CTRL_CLR_RX_UDF]) rx_udf_d = 1'b0;
  end

  // Sticky flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  assign status_word = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                   tx_ovf_q, rx_udf_q,
                                   STAT_CNT_W'(tx_count), STAT_CNT_W'(rx_count));

  // Read data mux; an empty RX head is already zero for the dropping mode
  always_comb begin
    rd_word = '0;
    if (data_rd)      rd_word = zero_pad(rx_head);
    else if (stat_rd) rd_word = status_word;
  end

  assign bus_drive          = rst & (data_rd | stat_rd);
  assign peripheralBus_data = bus_drive ? rd_word : {BUS_W{1'bz}};

  assign writeData       = tx_head;
  assign writeData_valid = ~tx_empty;
  assign readData_ready  = ~rx_full;

endmodule

// File: tb/tb_buffered_data_register.sv
module tb_buffered_data_register;

  localparam int DEPTH   = 4;
  localparam int OP_IDLE = 0;
  localparam int OP_DW   = 1;
  localparam int OP_DR   = 2;
  localparam int OP_SW   = 3;
  localparam int OP_SR   = 4;
  localparam int OP_BOTH = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  en, we, oe, wr_rdy, rd_vld, drv_en;
  logic [11:0] addr [2];
  logic [31:0] drv [2];
  logic [31:0] rd0;
  logic [7:0]  rd1;
  wire  [31:0] bus0, bus1;
  wire  [1:0]  busy, wd_vld, rd_rdy;
  wire  [31:0] wd0;
  wire  [7:0]  wd1;

  assign bus0 = drv_en[0] ? drv[0] : {32{1'bz}};
  assign bus1 = drv_en[1] ? drv[1] : {32{1'bz}};

  buffered_data_register #(.WIDTH(32), .DEPTH(DEPTH), .ADDRESS(12'h000),
    .STATUS_ADDRESS(12'h004), .BLOCKING(1)) dut0 (
    .clk(clk), .rst(rst_n), .enable(en[0]), .peripheralBus_we(we[0]),
    .peripheralBus_oe(oe[0]), .peripheralBus_busy(busy[0]),
    .peripheralBus_address(addr[0]), .peripheralBus_data(bus0),
    .writeData(wd0), .writeData_valid(wd_vld[0]), .writeData_ready(wr_rdy[0]),
    .readData(rd0), .readData_valid(rd_vld[0]), .readData_ready(rd_rdy[0]));

  buffered_data_register #(.WIDTH(8), .DEPTH(DEPTH), .ADDRESS(12'h010),
    .STATUS_ADDRESS(12'h014), .BLOCKING(0)) dut1 (
    .clk(clk), .rst(rst_n), .enable(en[1]), .peripheralBus_we(we[1]),
    .peripheralBus_oe(oe[1]), .peripheralBus_busy(busy[1]),
    .peripheralBus_address(addr[1]), .peripheralBus_data(bus1),
    .writeData(wd1), .writeData_valid(wd_vld[1]), .writeData_ready(wr_rdy[1]),
    .readData(rd1), .readData_valid(rd_vld[1]), .readData_ready(rd_rdy[1]));

  int total = 0;
  int bad   = 0;

  // Reference model: each FIFO is an ordered list with a fill level
  logic [31:0] mtx [2][DEPTH];
  logic [31:0] mrx [2][DEPTH];
  int          ntx [2];
  int          nrx [2];
  logic        movf [2];
  logic        mudf [2];

  // Observed and expected values of the last cycle
  logic        o_busy, o_wdv, o_rdr, e_busy, e_wdv, e_rdr;
  logic [31:0] o_wd, o_rd, e_wd, e_rd;

  function automatic logic [11:0] data_addr(input int u);
    return (u == 0) ? 12'h000 : 12'h010;
  endfunction

  function automatic logic [11:0] stat_addr(input int u);
    return (u == 0) ? 12'h004 : 12'h014;
  endfunction

  function automatic logic [31:0] wmask(input int u);
    return (u == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] model_status(input int u);
    logic [31:0] s;
    s = '0;
    s[0] = (ntx[u] == DEPTH);
    s[1] = (ntx[u] == 0);
    s[2] = (nrx[u] == DEPTH);
    s[3] = (nrx[u] == 0);
    s[4] = movf[u];
    s[5] = mudf[u];
    s = s + (32'(ntx[u]) * 32'h100) + (32'(nrx[u]) * 32'h1_0000);
    return s;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      ntx[u] = 0; nrx[u] = 0; movf[u] = 1'b0; mudf[u] = 1'b0;
    end
  endtask

  task automatic set_idle(input int u);
    en[u] = 1'b0; we[u] = 1'b0; oe[u] = 1'b0; drv_en[u] = 1'b0;
    wr_rdy[u] = 1'b0; rd_vld[u] = 1'b0; drv[u] = '0; addr[u] = '0;
  endtask

  // One clock of bus plus device activity; called just after a rising edge
  task automatic cycle(input int u, input int op, input logic [31:0] d,
                       input logic wr_ready, input logic rv, input logic [31:0] rdat);
    logic t_full, t_emp, r_full, r_emp;
    logic bus_push, bus_pop, dev_pop, dev_push, blk;
    en[u]     = (op != OP_IDLE);
    addr[u]   = (op == OP_DW || op == OP_DR || op == OP_BOTH) ? data_addr(u) : stat_addr(u);
    we[u]     = (op == OP_DW || op == OP_SW || op == OP_BOTH);
    oe[u]     = (op == OP_DR || op == OP_SR || op == OP_BOTH);
    drv_en[u] = we[u] & ~oe[u];
    drv[u]    = d;
    wr_rdy[u] = wr_ready;
    rd_vld[u] = rv;
    if (u == 0) rd0 = rdat; else rd1 = rdat[7:0];
    @(negedge clk);
    blk    = (u == 0);
    t_full = (ntx[u] == DEPTH); t_emp = (ntx[u] == 0);
    r_full = (nrx[u] == DEPTH); r_emp = (nrx[u] == 0);
    e_busy = blk && ((op == OP_DW && t_full) || (op == OP_DR && r_emp));
    e_wdv  = !t_emp;
    e_wd   = t_emp ? 32'h0 : mtx[u][0];
    e_rdr  = !r_full;
    e_rd   = (op == OP_DR) ? (r_emp ? 32'h0 : mrx[u][0]) :
             (op == OP_SR) ? model_status(u) : 32'h0;
    o_busy = busy[u];
    o_wdv  = wd_vld[u];
    o_wd   = (u == 0) ? wd0 : {24'h0, wd1};
    o_rdr  = rd_rdy[u];
    o_rd   = (u == 0) ? bus0 : bus1;
    @(posedge clk);
    bus_push = (op == OP_DW) && !t_full;
    bus_pop  = (op == OP_DR) && !r_emp;
    dev_pop  = wr_ready && !t_emp;
    dev_push = rv && !r_full;
    if (!blk && op == OP_DW && t_full) movf[u] = 1'b1;
    if (!blk && op == OP_DR && r_emp)  mudf[u] = 1'b1;
    if (op == OP_SW && d[4]) movf[u] = 1'b0;
    if (op == OP_SW && d[5]) mudf[u] = 1'b0;
    if (op == OP_SW && d[0]) ntx[u] = 0;
    else begin
      if (dev_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mtx[u][i] = mtx[u][i+1];
        ntx[u]--;
      end
      if (bus_push) begin mtx[u][ntx[u]] = d & wmask(u); ntx[u]++; end
    end
    if (op == OP_SW && d[1]) nrx[u] = 0;
    else begin
      if (bus_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mrx[u][i] = mrx[u][i+1];
        nrx[u]--;
      end
      if (dev_push) begin mrx[u][nrx[u]] = rdat & wmask(u); nrx[u]++; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle(0); set_idle(1);
    rd0 = '0; rd1 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      total++; if (busy[u] !== 1'b0) begin bad++; $display("FAIL rst_busy u=%0d got=%b want=0", u, busy[u]); end
      total++; if (wd_vld[u] !== 1'b0) begin bad++; $display("FAIL rst_wdv u=%0d got=%b want=0", u, wd_vld[u]); end
      total++; if (rd_rdy[u] !== 1'b1) begin bad++; $display("FAIL rst_rdr u=%0d got=%b want=1", u, rd_rdy[u]); end
    end
    total++; if (wd0 !== 32'h0) begin bad++; $display("FAIL rst_wd got=%h want=0", wd0); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int u = 0; u < 2; u++) begin
      cycle(u, OP_SR, 0, 0, 0, 0);
      total++; if (o_rd !== 32'h0000_000A) begin bad++; $display("FAIL rst_status u=%0d got=%h want=0000000a", u, o_rd); end
    end
    set_idle(0); set_idle(1);
  endtask

  task automatic test_tx_stall();
    logic [31:0] w [5];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44; w[4] = 32'h55;
    for (int i = 0; i < 4; i++) begin
      cycle(0, OP_DW, w[i], 0, 0, 0);
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL stall_fill_busy i=%0d got=%b want=0", i, o_busy); end
    end
    cycle(0, OP_SR, 0, 0, 0, 0);
    total++; if (o_rd !== 32'h0000_0409) begin bad++; $display("FAIL stall_status got=%h want=00000409", o_rd); end
    cycle(0, OP_DW, w[4], 0, 0, 0);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", o_busy); end
    cycle(0, OP_DW, w[4], 1, 0, 0);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL stall_pop_busy got=%b want=1", o_busy); end
    total++; if (o_wd !== 32'h11) begin bad++; $display("FAIL stall_pop_head got=%h want=11", o_wd); end
    cycle(0, OP_DW, w[4], 0, 0, 0);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", o_busy); end
    for (int i = 1; i < 5; i++) begin
      cycle(0, OP_IDLE, 0, 1, 0, 0);
      total++; if (o_wdv !== 1'b1 || o_wd !== w[i]) begin
        bad++; $display("FAIL stall_drain i=%0d got=%b/%h want=1/%h", i, o_wdv, o_wd, w[i]);
      end
    end
    cycle(0, OP_IDLE, 0, 1, 0, 0);
    total++; if (o_wdv !== 1'b0) begin bad++; $display("FAIL stall_drained got=%b want=0", o_wdv); end
    set_idle(0);
  endtask

  task automatic test_nonblocking();
    cycle(1, OP_DR, 0, 0, 0, 0);
    total++; if (o_busy !== 1'b0 || o_rd !== 32'h0) begin
      bad++; $display("FAIL nb_underflow_read got=%b/%h want=0/0", o_busy, o_rd);
    end
    cycle(1, OP_SR, 0, 0, 0, 0);
    total++; if (o_rd !== 32'h0000_002A) begin bad++; $display("FAIL nb_udf_flag got=%h want=0000002a", o_rd); end
    cycle(1, OP_SW, 32'h20, 0, 0, 0);
    cycle(1, OP_SR, 0, 0, 0, 0);
    total++; if (o_rd !== 32'h0000_000A) begin bad++; $display("FAIL nb_udf_clear got=%h want=0000000a", o_rd); end
    for (int i = 0; i < 5; i++) begin
      cycle(1, OP_DW, 32'h100 + 32'(i), 0, 0, 0);
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL nb_write_busy i=%0d got=%b want=0", i, o_busy); end
    end
    cycle(1, OP_SR, 0, 0, 0, 0);
    total++; if (o_rd !== 32'h0000_0419) begin bad++; $display("FAIL nb_ovf_flag got=%h want=00000419", o_rd); end
    cycle(1, OP_SW, 32'h11, 0, 0, 0);
    cycle(1, OP_SR, 0, 0, 0, 0);
    total++; if (o_rd !== 32'h0000_000A) begin bad++; $display("FAIL nb_flush_clear got=%h want=0000000a", o_rd); end
    set_idle(1);
  endtask

  task automatic test_width8();
    cycle(1, OP_IDLE, 0, 0, 1, 32'hA5);
    cycle(1, OP_IDLE, 0, 0, 1, 32'h3C);
    cycle(1, OP_SR, 0, 0, 0, 0);
    total++; if (o_rd[20:16] !== 5'd2) begin bad++; $display("FAIL w8_count2 got=%0d want=2", o_rd[20:16]); end
    cycle(1, OP_DR, 0, 0, 0, 0);
    total++; if (o_rd !== 32'h0000_00A5) begin bad++; $display("FAIL w8_read1 got=%h want=000000a5", o_rd); end
    cycle(1, OP_SR, 0, 0, 0, 0);
    total++; if (o_rd[20:16] !== 5'd1) begin bad++; $display("FAIL w8_count1 got=%0d want=1", o_rd[20:16]); end
    cycle(1, OP_DR, 0, 0, 1, 32'h77);
    total++; if (o_rd !== 32'h0000_003C) begin bad++; $display("FAIL w8_read2 got=%h want=0000003c", o_rd); end
    cycle(1, OP_SR, 0, 0, 0, 0);
    total++; if (o_rd !== 32'h0001_0002) begin bad++; $display("FAIL w8_pushpop got=%h want=00010002", o_rd); end
    cycle(1, OP_DR, 0, 0, 0, 0);
    total++; if (o_rd !== 32'h0000_0077) begin bad++; $display("FAIL w8_read3 got=%h want=00000077", o_rd); end
    set_idle(1);
  endtask

  task automatic test_flush_pop();
    for (int i = 0; i < 3; i++) cycle(0, OP_DW, 32'hA0 + 32'(i), 0, 0, 0);
    cycle(0, OP_SW, 32'h1, 1, 0, 0);
    total++; if (o_wd !== 32'hA0) begin bad++; $display("FAIL flush_head got=%h want=a0", o_wd); end
    cycle(0, OP_SR, 0, 1, 0, 0);
    total++; if (o_rd !== 32'h0000_000A) begin bad++; $display("FAIL flush_status got=%h want=0000000a", o_rd); end
    total++; if (o_wdv !== 1'b0) begin bad++; $display("FAIL flush_reemit got=%b want=0", o_wdv); end
    set_idle(0);
  endtask

  task automatic test_reset_mid_access();
    for (int i = 0; i < 4; i++) cycle(0, OP_DW, 32'hB0 + 32'(i), 0, 0, 0);
    en[0] = 1'b1; we[0] = 1'b1; oe[0] = 1'b0; addr[0] = data_addr(0);
    drv_en[0] = 1'b1; drv[0] = 32'hBB;
    @(negedge clk);
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL mid_stall got=%b want=1", busy[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL mid_busy_drop got=%b want=0", busy[0]); end
    total++; if (wd_vld[0] !== 1'b0) begin bad++; $display("FAIL mid_wdv got=%b want=0", wd_vld[0]); end
    set_idle(0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    cycle(0, OP_SR, 0, 0, 0, 0);
    total++; if (o_rd !== 32'h0000_000A) begin bad++; $display("FAIL mid_status got=%h want=0000000a", o_rd); end
    set_idle(0);
  endtask

  task automatic test_random();
    int          r, op;
    logic [31:0] d;
    logic        wr, rv;
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 600; c++) begin
        r = $urandom_range(0, 9);
        op = (r < 3) ? OP_DW : (r < 6) ? OP_DR : (r == 6) ? OP_SR :
             (r == 7) ? OP_SW : (r == 8) ? OP_IDLE : OP_BOTH;
        d = $urandom;
        if (op == OP_SW && $urandom_range(0, 5) != 0) d[1:0] = 2'b00;
        if (((c / 100) % 2) == 0) begin
          wr = ($urandom_range(0, 3) == 0); rv = ($urandom_range(0, 1) == 0);
        end else begin
          wr = ($urandom_range(0, 1) == 0); rv = ($urandom_range(0, 3) == 0);
        end
        cycle(u, op, d, wr, rv, $urandom);
        total++; if (o_busy !== e_busy) begin bad++; $display("FAIL rnd_busy u=%0d c=%0d got=%b want=%b", u, c, o_busy, e_busy); end
        total++; if (o_wdv !== e_wdv) begin bad++; $display("FAIL rnd_wdv u=%0d c=%0d got=%b want=%b", u, c, o_wdv, e_wdv); end
        total++; if (o_wd !== e_wd) begin bad++; $display("FAIL rnd_wd u=%0d c=%0d got=%h want=%h", u, c, o_wd, e_wd); end
        total++; if (o_rdr !== e_rdr) begin bad++; $display("FAIL rnd_rdr u=%0d c=%0d got=%b want=%b", u, c, o_rdr, e_rdr); end
        if (!e_busy && (op == OP_DR || op == OP_SR)) begin
          total++; if (o_rd !== e_rd) begin bad++; $display("FAIL rnd_rd u=%0d c=%0d op=%0d got=%h want=%h", u, c, op, o_rd, e_rd); end
        end
      end
      set_idle(u);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle(0);
    set_idle(1);
    rd0 = '0;
    rd1 = '0;
    model_reset();
    test_reset();
    test_tx_stall();
    test_nonblocking();
    test_width8();
    test_flush_pop();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
